mult_share_arb: RTL and testbench

Round-robin scheduler that shares one combinational 64x64 array multiplier among NREQ requesters. It arbitrates operand requests, registers the winning operands onto the multiplier inputs, and captures the 128-bit product. It returns the product with the requester's index on a single valid/ready response port. It sits between the requesting engines and the multiplier instance, which remains a separate purely combinational block.

---
 rtl/mult_share_arb.sv | 96 +++++++++
 tb/tb_mult_share_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin scheduler sharing one combinational multiplier
// Two-stage pipeline: OP stage drives the multiplier, RSP stage holds the captured product.
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 64,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_sum,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_prod,
  output logic              busy
);

  logic            op_valid;
  logic [IDW-1:0]  op_id;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  nptr;
  logic [IDW:0]    idx;
  logic            found;
  logic            rsp_adv;
  logic            op_adv;
  logic            load_en;
  logic            accept;

  assign rsp_adv = !rsp_valid | rsp_ready;
  assign op_adv  = op_valid & rsp_adv;
  assign load_en = !op_valid | rsp_adv;

  // Scan ptr, ptr+1, ... wrapping at NREQ (which need not be a power of two).
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found                = 1'b1;
        grant[idx[IDW-1:0]] = 1'b1;
        gid                  = idx[IDW-1:0];
      end
    end
  end

  assign nptr      = (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);
  assign req_ready = grant & {NREQ{load_en}};
  assign accept    = |req_ready;
  assign busy      = op_valid | rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      op_valid <= 1'b0;
      op_id    <= '0;
      ptr      <= '0;
    end else if (accept) begin
      mul_a    <= req_a[int'(gid)*W +: W];
      mul_b    <= req_b[int'(gid)*W +: W];
      op_id    <= gid;
      op_valid <= 1'b1;
      ptr      <= nptr;
    end else if (op_adv) begin
      // Operands are left in place so the multiplier inputs stay quiet.
      op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
    end else if (op_adv) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id;
      rsp_prod  <= mul_sum;
    end else if (rsp_adv) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - scoreboard bench for mult_share_arb
// Requester model holds requests until granted; expected products come from plain multiplication.
module tb_mult_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_sum;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_prod;
  logic              busy;

  mult_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_sum(mul_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_prod(rsp_prod), .busy(busy)
  );

  assign mul_sum = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

  always #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [2*W-1:0] prod;
    int             acc;
  } item_t;

  item_t           sb[$];
  int              gseq[$];
  logic [NREQ-1:0] pend = '0;
  logic [W-1:0]    pa[NREQ];
  logic [W-1:0]    pb[NREQ];
  int              mptr = 0;
  int              cyc = 0;
  int              nchk = 0;
  int              nerr = 0;
  int              nacc = 0;
  int              nrsp = 0;
  int              last_grant = -1;
  logic [NREQ-1:0] last_ready;
  logic [2*W-1:0]  last_prod = '0;
  logic            mon_en = 1'b0;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand64();
    case ($urandom % 8)
      0: rand64 = '1;
      1: rand64 = '0;
      default: rand64 = {$urandom, $urandom};
    endcase
  endfunction

  // One clock of stimulus; the expected grant comes from the pointer plus pipeline occupancy.
  task automatic tick(input logic rr);
    int eg;
    logic [2*W-1:0] ea, eb;
    @(negedge clk);
    cyc++;
    rsp_ready = rr;
    req_valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = pa[i];
      req_b[i*W +: W] = pb[i];
    end
    #2;
    eg = -1;
    if (sb.size() < 2 || rr) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (mptr + k) % NREQ;
        if (eg < 0 && pend[idx]) eg = idx;
      end
    end
    last_ready = req_ready;
    chk("req_ready", req_ready, (eg >= 0) ? (128'd1 << eg) : 128'd0);
    chk("busy", busy, sb.size() != 0);
    last_grant = eg;
    if (eg >= 0) begin
      ea = {{W{1'b0}}, pa[eg]};
      eb = {{W{1'b0}}, pb[eg]};
      sb.push_back('{eg, ea * eb, cyc});
      mptr = (eg + 1) % NREQ;
      pend[eg] = 1'b0;
      nacc++;
      gseq.push_back(eg);
    end
  endtask

  task automatic gen_all();
    for (int i = 0; i < NREQ; i++)
      if (!pend[i]) begin
        pend[i] = 1'b1;
        pa[i] = W'(i + 1);
        pb[i] = W'(10);
      end
  endtask

  task automatic gen_rand();
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && ($urandom % 3 == 0)) begin
        pend[i] = 1'b1;
        pa[i] = rand64();
        pb[i] = rand64();
      end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend != '0 || sb.size() != 0) && n < 60) begin
      tick(1'b1);
      n++;
    end
    chk("drain_done", (pend == '0) && (sb.size() == 0), 1'b1);
  endtask

  // Monitor: checks response timing and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    #4;
    if (mon_en) begin : mon
      item_t it;
      logic exp_rv;
      exp_rv = (sb.size() > 0) && (sb[0].acc < cyc - 1);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL spurious_rsp: got id %0d with empty scoreboard", rsp_id);
        end else begin
          it = sb.pop_front();
          chk("rsp_id", rsp_id, it.id);
          chk("rsp_prod", rsp_prod, it.prod);
          last_prod = rsp_prod;
          nrsp++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    #12;
    chk("rst_mul_a", mul_a, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_prod", rsp_prod, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    #5 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single request on requester 2.
    pend[2] = 1'b1; pa[2] = 64'd3; pb[2] = 64'd5;
    tick(1'b1);
    chk("first_ready", last_ready, 4'b0100);
    drain();
    chk("first_prod", last_prod, 128'd15);
    tick(1'b1);
    chk("busy_idle", busy, 0);

    // Full-scale operands.
    pend[0] = 1'b1; pa[0] = '1; pb[0] = '1;
    drain();
    chk("max_prod", last_prod, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Continuous streams, one grant per cycle in rotation.
    gseq.delete();
    for (int c = 0; c < 12; c++) begin
      gen_all();
      tick(1'b1);
    end
    chk("stream_count", gseq.size(), 12);
    for (int n = 1; n < gseq.size(); n++)
      chk("stream_rotation", gseq[n], (gseq[n-1] + 1) % NREQ);
    drain();

    // Downstream stall from an empty pipeline.
    n0 = nacc;
    for (int c = 0; c < 6; c++) begin
      gen_all();
      tick(1'b0);
    end
    chk("stall_accepts", nacc - n0, 2);
    pend = '0;
    drain();
    chk("stall_no_loss", nrsp, nacc);

    // Pointer at 2 with only requesters 1 and 3 valid.
    pend[1] = 1'b1; pa[1] = 64'd7; pb[1] = 64'd6;
    drain();
    gseq.delete();
    pend[1] = 1'b1; pa[1] = 64'd11; pb[1] = 64'd13;
    pend[3] = 1'b1; pa[3] = 64'd17; pb[3] = 64'd19;
    drain();
    chk("ptr_grant_cnt", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("ptr_grant0", gseq[0], 3);
      chk("ptr_grant1", gseq[1], 1);
    end
    gseq.delete();
    gen_all();
    tick(1'b1);
    chk("ptr_back_to_2", last_ready, 4'b0100);
    drain();

    // Reset with both stages full.
    gen_all();
    tick(1'b0);
    tick(1'b0);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_mul_b", mul_b, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_id", rsp_id, 0);
    chk("mid_rst_rsp_prod", rsp_prod, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    nacc = nacc - sb.size();
    sb.delete();
    pend = '0;
    mptr = 0;
    #3 rst_n = 1'b1;
    mon_en = 1'b1;
    gen_all();
    tick(1'b1);
    chk("post_rst_grant", last_ready, 4'b0001);
    drain();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      gen_rand();
      tick(($urandom % 4) != 0);
    end
    drain();
    chk("total_rsp", nrsp, nacc);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
